keypad_scanner: RTL and testbench

- Input-side counterpart of the four-digit display multiplexer. It scans a 4x4 matrix keypad by driving columns one-cold and reading the rows.
- Each key is debounced over whole scans, then encoded to a 4-bit hex code. The CPU or display path receives that code with a one-cycle valid pulse and a held level.
- The block sits between the board keypad pins and the data-entry logic. It shares the system clock and reset.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_scanner_if.sv | 17 +
 rtl/keypad_tick_gen.sv | 24 ++
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_keypad_scanner.sv | 133 +++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   state_t    : press/release FSM states
//   scan_cls_t : result of classifying one full scan snapshot
//   classify() : counts pressed keys in a snapshot and returns the class
//                and, for a single key, its code (row*4 + col).
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_cls_t;

  typedef struct packed {
    scan_cls_t  cls;
    logic [3:0] code;
  } scan_res_t;

  function automatic scan_res_t classify(input logic [NUM_KEYS-1:0] snap);
    scan_res_t res;
    int        n;
    res.cls  = NONE;
    res.code = '0;
    n        = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (snap[i]) begin
        n++;
        res.code = 4'(i);
      end
    end
    if (n == 1)     res.cls = SINGLE;
    else if (n > 1) res.cls = MULTI;
    return res;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle.
//   row       : keypad rows, active-low, asynchronous
//   col       : column drive, one-cold
//   key_code  : last accepted key code
//   key_valid : one-clk press-accepted pulse
//   key_held  : high while an accepted key is held
// master = scanner side, slave = board/consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output col, output key_code, output key_valid, output key_held);
  modport slave  (output row, input col, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running column-step divider.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : one-clk enable every SCAN_DIV clocks; the first one is
//                consumed SCAN_DIV clocks after reset is released.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 250_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int          W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debouncing.
//   clk, reset : system clock, synchronous active-high reset
//   kp         : keypad_scanner_if.master (row in; col, key_code,
//                key_valid, key_held out)
// Columns are driven one-cold and stepped on every tick; rows are sampled
// through a 2-flop synchronizer into a 16-bit snapshot. At the end of each
// full scan the snapshot is classified and a small FSM debounces presses
// and releases over DEBOUNCE_SCANS consecutive scans.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 250_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master kp
);
  localparam int           CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);

  logic                tick, scan_done;
  logic [3:0]          row_s1, row_s2;
  logic [1:0]          col_idx;
  logic [NUM_KEYS-1:0] snap, scan_now;
  scan_res_t           res;

  state_t      state, state_n;
  logic [3:0]  cand, cand_n, code_n;
  logic [CW-1:0] cnt, cnt_n, rel, rel_n;
  logic        held_n, accept;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Snapshot as it will look after this tick's capture, so the column-3
  // tick can classify the complete scan on the same edge.
  always_comb begin
    scan_now = snap;
    for (int r = 0; r < NUM_ROWS; r++)
      scan_now[r*NUM_COLS + int'(col_idx)] = ~row_s2[r];
  end

  assign scan_done = tick && (col_idx == 2'd3);
  assign res       = classify(scan_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      col_idx <= '0;
      kp.col  <= 4'b1110;
      snap    <= '0;
    end else begin
      row_s1 <= kp.row;
      row_s2 <= row_s1;
      if (tick) begin
        snap    <= scan_now;
        col_idx <= col_idx + 2'd1;
        kp.col  <= ~(4'b0001 << (col_idx + 2'd1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      rel          <= '0;
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      state        <= state_n;
      cand         <= cand_n;
      cnt          <= cnt_n;
      rel          <= rel_n;
      kp.key_code  <= code_n;
      kp.key_valid <= accept;
      kp.key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    rel_n   = rel;
    code_n  = kp.key_code;
    held_n  = kp.key_held;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (res.cls == SINGLE) begin
            cand_n = res.code;
            if (DB == CW'(1)) accept = 1'b1;
            else begin
              cnt_n   = CW'(1);
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          // A different key aborts; it is picked up fresh from IDLE later.
          if (res.cls == SINGLE && res.code == cand) begin
            if (cnt + 1'b1 == DB) accept = 1'b1;
            else                  cnt_n  = cnt + 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (res.cls == NONE) begin
            if (rel + 1'b1 == DB) begin
              held_n  = 1'b0;
              state_n = IDLE;
              rel_n   = '0;
            end else begin
              rel_n = rel + 1'b1;
            end
          end else begin
            rel_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
      if (accept) begin
        code_n  = cand_n;
        held_n  = 1'b1;
        state_n = PRESSED;
        cnt_n   = '0;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A behavioural keypad pulls row[r] low while a pressed key (r,c) has its
// column driven low. Edge numbers in comments count clocks since reset release;
// scans complete on multiples of 16.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          p0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.master)
  );

  always #5 clk = ~clk;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign kp.row[r] = ~|(keys[r*4 +: 4] & ~kp.col);
  end

  always @(negedge clk) if (kp.key_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] code, input logic vld, input logic held);
    chk({tag, ".code"}, 32'(kp.key_code), 32'(code));
    chk({tag, ".valid"}, 32'(kp.key_valid), 32'(vld));
    chk({tag, ".held"}, 32'(kp.key_held), 32'(held));
  endtask

  initial begin
    keys  = '0;
    reset = 1'b1;
    clk_n(3);
    chk("rst.col", 32'(kp.col), 32'hE);
    chk_out("rst", 4'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Column stepping: one step every 4 clocks.
    clk_n(3);  chk("col.e3", 32'(kp.col), 32'hE);
    clk_n(1);  chk("col.e4", 32'(kp.col), 32'hD);
    clk_n(4);  chk("col.e8", 32'(kp.col), 32'hB);
    clk_n(4);  chk("col.e12", 32'(kp.col), 32'h7);
    clk_n(4);  chk("col.e16", 32'(kp.col), 32'hE);

    // Key 6 (row1/col2): scans 32,48,64 match -> accept at edge 64.
    p0   = pulses;
    keys = 16'h1 << 6;
    clk_n(47); chk_out("k6.pre", 4'h0, 1'b0, 1'b0);
    clk_n(1);  chk_out("k6.acc", 4'h6, 1'b1, 1'b1);
    clk_n(1);  chk_out("k6.post", 4'h6, 1'b0, 1'b1);
    clk_n(47);                               // edge 112, six scans held
    chk("k6.pulses", 32'(pulses - p0), 32'd1);
    keys = '0;                               // NONE scans 128,144,160
    clk_n(47); chk_out("k6.relpre", 4'h6, 1'b0, 1'b1);
    clk_n(1);  chk_out("k6.rel", 4'h6, 1'b0, 1'b0);

    // Bouncing key F on alternate scans.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? (16'h1 << 15) : 16'h0;
      clk_n(16);
    end
    chk("bounce.pulses", 32'(pulses - p0), 32'd0);
    chk("bounce.held", 32'(kp.key_held), 32'd0);

    // Keys 0 and 5 together -> ghost risk, ignored; then key 0 alone.
    keys = 16'h0021;
    clk_n(64);                               // edge 352
    chk("multi.pulses", 32'(pulses - p0), 32'd0);
    chk("multi.held", 32'(kp.key_held), 32'd0);
    keys = 16'h0001;                         // scans 368,384,400
    clk_n(47); chk_out("k0.pre", 4'h6, 1'b0, 1'b0);
    clk_n(1);  chk_out("k0.acc", 4'h0, 1'b1, 1'b1);

    // Release key 0, press key 9, then reset while 9 is held.
    keys = '0;
    clk_n(48); chk("k0.rel", 32'(kp.key_held), 32'd0);
    keys = 16'h1 << 9;
    clk_n(48); chk_out("k9.acc", 4'h9, 1'b1, 1'b1);
    clk_n(5);
    reset = 1'b1;
    clk_n(1);
    chk("rst2.col", 32'(kp.col), 32'hE);
    chk_out("rst2", 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    p0 = pulses;
    clk_n(47); chk_out("k9b.pre", 4'h0, 1'b0, 1'b0);
    chk("k9b.nopulse", 32'(pulses - p0), 32'd0);
    clk_n(1);  chk_out("k9b.acc", 4'h9, 1'b1, 1'b1);
    clk_n(1);  chk_out("k9b.post", 4'h9, 1'b0, 1'b1);

    // Second key added for one scan while 9 is held: no new pulse.
    p0   = pulses;
    keys = (16'h1 << 9) | (16'h1 << 3);
    clk_n(15);                               // edge 64: MULTI scan
    keys = 16'h1 << 9;
    clk_n(48);                               // edge 112
    chk("ab.pulses", 32'(pulses - p0), 32'd0);
    chk_out("ab.hold", 4'h9, 1'b0, 1'b1);

    // Two NONE scans, one MULTI scan must clear the release count.
    keys = '0;
    clk_n(32);
    keys = (16'h1 << 9) | (16'h1 << 3);
    clk_n(16);
    keys = '0;
    clk_n(32); chk("relrst.held", 32'(kp.key_held), 32'd1);
    clk_n(16); chk_out("relrst.rel", 4'h9, 1'b0, 1'b0);
    chk("end.pulses", 32'(pulses - p0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
